flex_timer: RTL and testbench

FLEX_TIMER -- requirements
Module: flex_timer

---
 rtl/flex_pkg.sv | 26 ++
 rtl/flex_next_count.sv | 56 +++++
 rtl/flex_timer.sv | 91 +++++++++
 tb/tb_flex_timer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/flex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flex_pkg
// Description : Counting-mode type and mode helpers shared by the flex timer.
// Revision    : 1.0 - initial release
// ============================================================================
package flex_pkg;

    typedef enum logic [1:0] {
        UP_WRAP      = 2'd0,
        DOWN_WRAP    = 2'd1,
        UP_ONESHOT   = 2'd2,
        DOWN_ONESHOT = 2'd3
    } cnt_mode_t;

    // Terminal select: 1 means the terminal is the rollover value, 0 means it is 1
    function automatic logic term_is_rollover(input cnt_mode_t mode);
        return (mode == UP_WRAP) || (mode == UP_ONESHOT);
    endfunction

    function automatic logic is_oneshot(input cnt_mode_t mode);
        return (mode == UP_ONESHOT) || (mode == DOWN_ONESHOT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flex_next_count.sv
`default_nettype none
// ============================================================================
// Module      : flex_next_count
// Description : Combinational next-count and terminal detection for flex_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_next_count
    import flex_pkg::*;
#(
    parameter int NUM_CNT_BITS = 8
) (
    input  logic [NUM_CNT_BITS-1:0] count,
    input  cnt_mode_t               mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] next_count,
    output logic                    at_terminal
);

    localparam logic [NUM_CNT_BITS-1:0] c_ONE = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS:0]   c_ONE_EXT = (NUM_CNT_BITS+1)'(1);

    logic [NUM_CNT_BITS:0]   w_count_ext;
    logic [NUM_CNT_BITS:0]   w_roll_ext;
    logic [NUM_CNT_BITS:0]   w_inc;
    logic [NUM_CNT_BITS:0]   w_dec;
    logic [NUM_CNT_BITS-1:0] w_term;
    logic                    w_roll_zero;

    assign w_count_ext = {1'b0, count};
    assign w_roll_ext  = {1'b0, rollover_val};
    assign w_inc       = w_count_ext + c_ONE_EXT;
    assign w_dec       = w_count_ext - c_ONE_EXT;
    assign w_roll_zero = (rollover_val == '0);
    assign w_term      = term_is_rollover(mode) ? rollover_val : c_ONE;

    always_comb begin
        next_count = count;
        if (!w_roll_zero) begin
            if (term_is_rollover(mode)) begin
                // count+1 <= R at full width is count < R with no carry loss
                next_count = (w_inc <= w_roll_ext) ? w_inc[NUM_CNT_BITS-1:0] : c_ONE;
            end else begin
                // borrow out of the decrement marks count == 0
                if (w_dec[NUM_CNT_BITS] || (count == c_ONE) || (w_count_ext > w_roll_ext)) begin
                    next_count = rollover_val;
                end else begin
                    next_count = w_dec[NUM_CNT_BITS-1:0];
                end
            end
        end
    end

    assign at_terminal = !w_roll_zero && (next_count == w_term);

endmodule
`default_nettype wire

// File: rtl/flex_timer.sv
`default_nettype none
// ============================================================================
// Module      : flex_timer
// Description : Up/down wrap or one-shot timer with clear, load and rollover flags.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_timer
    import flex_pkg::*;
#(
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  cnt_mode_t               mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_pulse,
    output logic                    done
);

    localparam logic [NUM_CNT_BITS-1:0] c_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic                    r_pulse;
    logic                    r_done;
    logic [NUM_CNT_BITS-1:0] w_next;
    logic [NUM_CNT_BITS-1:0] w_count_d;
    logic [NUM_CNT_BITS-1:0] w_term;
    logic                    w_at_term;
    logic                    w_step;
    logic                    w_flag_d;

    flex_next_count #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_next_count (
        .count        (r_count),
        .mode         (mode),
        .rollover_val (rollover_val),
        .next_count   (w_next),
        .at_terminal  (w_at_term)
    );

    assign w_term = term_is_rollover(mode) ? rollover_val : c_ONE;
    // A finished one-shot ignores enables until clear, load or reset
    assign w_step = count_enable && !(r_done && is_oneshot(mode));

    always_comb begin
        w_count_d = r_count;
        if (clear) begin
            w_count_d = '0;
        end else if (load) begin
            w_count_d = load_val;
        end else if (w_step) begin
            w_count_d = w_next;
        end
    end

    // Flag follows the value being registered, so it lines up with count_out
    assign w_flag_d = (rollover_val != '0) && (w_count_d == w_term);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_flag  <= w_flag_d;
            r_pulse <= !clear && !load && w_step && w_at_term;
            if (clear || load) begin
                r_done <= 1'b0;
            end else if (w_step && is_oneshot(mode) && w_at_term) begin
                r_done <= 1'b1;
            end
        end
    end

    assign count_out      = r_count;
    assign rollover_flag  = r_flag;
    assign rollover_pulse = r_pulse;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_flex_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_timer
// Description : Directed and randomized self-checking bench for flex_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_timer;
    import flex_pkg::*;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic       rst, clear, count_enable, load;
    logic [7:0] load_val, rollover_val;
    cnt_mode_t  mode;
    logic [7:0] count_out;
    logic       rollover_flag, rollover_pulse, done;

    logic       rst4;
    logic       clear4 = 1'b0;
    logic       en4;
    logic       load4 = 1'b0;
    logic [3:0] load_val4 = 4'd0;
    logic [3:0] rollover_val4;
    cnt_mode_t  mode4;
    logic [3:0] count_out4;
    logic       flag4, pulse4, done4;

    flex_timer #(.NUM_CNT_BITS(8)) dut (
        .clk            (tb_clk),
        .rst            (rst),
        .clear          (clear),
        .count_enable   (count_enable),
        .load           (load),
        .load_val       (load_val),
        .mode           (mode),
        .rollover_val   (rollover_val),
        .count_out      (count_out),
        .rollover_flag  (rollover_flag),
        .rollover_pulse (rollover_pulse),
        .done           (done)
    );

    flex_timer #(.NUM_CNT_BITS(4)) dut4 (
        .clk            (tb_clk),
        .rst            (rst4),
        .clear          (clear4),
        .count_enable   (en4),
        .load           (load4),
        .load_val       (load_val4),
        .mode           (mode4),
        .rollover_val   (rollover_val4),
        .count_out      (count_out4),
        .rollover_flag  (flag4),
        .rollover_pulse (pulse4),
        .done           (done4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state for the 8-bit instance, kept as plain integers
    int m_count = 0;
    bit m_done  = 1'b0;
    bit m_flag  = 1'b0;
    bit m_pulse = 1'b0;

    function automatic bit ref_up(input cnt_mode_t md);
        return (md == UP_WRAP) || (md == UP_ONESHOT);
    endfunction

    function automatic int ref_term(input cnt_mode_t md, input int r);
        return ref_up(md) ? r : 1;
    endfunction

    function automatic int ref_step(input int c, input cnt_mode_t md, input int r);
        if (r == 0) return c;
        if (ref_up(md)) return (c < r) ? c + 1 : 1;
        return (c <= 1 || c > r) ? r : c - 1;
    endfunction

    task automatic model_edge();
        bit os;
        int r;
        os = (mode == UP_ONESHOT) || (mode == DOWN_ONESHOT);
        r  = int'(rollover_val);
        if (rst || clear) begin
            m_count = 0; m_done = 1'b0; m_pulse = 1'b0;
        end else if (load) begin
            m_count = int'(load_val); m_done = 1'b0; m_pulse = 1'b0;
        end else if (count_enable && !(m_done && os)) begin
            m_count = ref_step(m_count, mode, r);
            m_pulse = (r != 0) && (m_count == ref_term(mode, r));
            if (os && m_pulse) m_done = 1'b1;
        end else begin
            m_pulse = 1'b0;
        end
        m_flag = (r != 0) && (m_count == ref_term(mode, r));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge tb_clk);
        #1;
        check("count", 32'(count_out), 32'(m_count));
        check("flag", 32'(rollover_flag), 32'(m_flag));
        check("pulse", 32'(rollover_pulse), 32'(m_pulse));
        check("done", 32'(done), 32'(m_done));
    endtask

    initial begin
        int up5[7];
        int dn4[6];
        int npulse;
        up5 = '{1, 2, 3, 4, 5, 1, 2};
        dn4 = '{4, 3, 2, 1, 1, 1};

        rst = 1'b1; clear = 1'b0; count_enable = 1'b1; load = 1'b1;
        load_val = 8'h55; mode = UP_WRAP; rollover_val = 8'd5;
        rst4 = 1'b1; en4 = 1'b0; mode4 = UP_WRAP; rollover_val4 = 4'd15;

        // Reset wins over load and enable
        tick();
        tick();
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_flags", 32'({rollover_flag, rollover_pulse, done}), 32'd0);

        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("up5_seq", 32'(count_out), 32'(up5[i]));
            check("up5_pulse", 32'(rollover_pulse), 32'(up5[i] == 5));
        end

        count_enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; count_enable = 1'b1; mode = DOWN_ONESHOT; rollover_val = 8'd4;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("dn4_seq", 32'(count_out), 32'(dn4[i]));
            check("dn4_done", 32'(done), 32'(i >= 3));
            npulse += int'(rollover_pulse);
        end
        check("dn4_pulses", 32'(npulse), 32'd1);

        // Lowering R below the current count wraps on the next step
        mode = UP_WRAP; rollover_val = 8'd10; count_enable = 1'b0; load = 1'b1; load_val = 8'd9;
        tick();
        load = 1'b0; rollover_val = 8'd6; count_enable = 1'b1;
        tick();
        check("r_lowered", 32'(count_out), 32'd1);
        load = 1'b1; load_val = 8'd6;
        tick();
        check("load_term_cnt", 32'(count_out), 32'd6);
        check("load_term_flag", 32'(rollover_flag), 32'd1);
        check("load_term_pulse", 32'(rollover_pulse), 32'd0);

        load_val = 8'd200; count_enable = 1'b0;
        tick();
        load = 1'b0; count_enable = 1'b1;
        tick();
        check("above_r_wrap", 32'(count_out), 32'd1);

        load = 1'b1; load_val = 8'd3; count_enable = 1'b0;
        tick();
        clear = 1'b1; load = 1'b1; count_enable = 1'b1;
        tick();
        check("clear_prio", 32'(count_out), 32'd0);
        clear = 1'b0; load = 1'b0; rollover_val = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r0_count", 32'(count_out), 32'd0);
            check("r0_flag", 32'(rollover_flag), 32'd0);
        end

        rollover_val = 8'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r1_count", 32'(count_out), 32'd1);
            check("r1_pulse", 32'(rollover_pulse), 32'd1);
        end

        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            clear        = ($urandom_range(0, 99) < 4);
            load         = ($urandom_range(0, 99) < 8);
            count_enable = ($urandom_range(0, 99) < 75);
            load_val     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) mode = cnt_mode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                rollover_val = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            tick();
        end

        // Narrow instance: full-range period must wrap cleanly at 15
        @(negedge tb_clk);
        rst4 = 1'b0; en4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge tb_clk);
            #1;
            check("w4_count", 32'(count_out4), 32'((i < 15) ? i + 1 : 1));
            check("w4_pulse", 32'(pulse4), 32'(i == 14));
            check("w4_flag", 32'(flag4), 32'(i == 14));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
